// File: rtl/digest_stream_buffer_pkg.sv
// Shared constants, FSM encoding and helpers for the digest stream buffer.
package digest_stream_buffer_pkg;

  // SHA-256 digest geometry: eight 32-bit words, A..H.
  localparam int DIGEST_WORDS  = 8;
  localparam int DIGEST_WORD_W = 32;

  // Stream FSM encoding.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } stream_state_e;

  // Number of full banks given the two full flags.
  function automatic logic [1:0] full_count(input logic [1:0] full);
    return {1'b0, full[0]} + {1'b0, full[1]};
  endfunction

endpackage

// File: rtl/digest_stream_buffer_if.sv
// Word-by-word stream handshake carrying one digest out of the buffer.
interface digest_stream_buffer_if #(
  parameter int WORD_W = 32
);

  logic [WORD_W-1:0] stream_data;
  logic              stream_valid;
  logic              stream_ready;
  logic              stream_last;

  // The buffer sources words; the host/serial side sinks them.
  modport master (
    output stream_data,
    output stream_valid,
    output stream_last,
    input  stream_ready
  );

  modport slave (
    input  stream_data,
    input  stream_valid,
    input  stream_last,
    output stream_ready
  );

endinterface

// File: rtl/digest_stream_buffer_bank.sv
// One NUM_WORDS x WORD_W digest bank: parallel write of a whole digest,
// two independent combinational read ports addressed 1..NUM_WORDS.
// Out-of-range addresses read as zero. Contents are deliberately not reset.
module digest_stream_buffer_bank
  import digest_stream_buffer_pkg::*;
#(
  parameter int WORD_W    = DIGEST_WORD_W,
  parameter int NUM_WORDS = DIGEST_WORDS,
  parameter int ADDR_W    = 4
) (
  input  logic                        clk,
  input  logic                        we_i,
  input  logic [NUM_WORDS*WORD_W-1:0] words_i,
  input  logic [ADDR_W-1:0]           addr_a_i,
  output logic [WORD_W-1:0]           data_a_o,
  input  logic [ADDR_W-1:0]           addr_b_i,
  output logic [WORD_W-1:0]           data_b_o
);

  logic [WORD_W-1:0] mem_q [NUM_WORDS];

  // Capture every word of the incoming digest on a write pulse.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        mem_q[k] <= words_i[k*WORD_W +: WORD_W];
      end
    end
  end

  // One-hot OR mux for both read ports; no address hit yields zero.
  always_comb begin
    data_a_o = '0;
    data_b_o = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      data_a_o = data_a_o | ({WORD_W{addr_a_i == ADDR_W'(k + 1)}} & mem_q[k]);
      data_b_o = data_b_o | ({WORD_W{addr_b_i == ADDR_W'(k + 1)}} & mem_q[k]);
    end
  end

endmodule

// File: rtl/digest_stream_buffer.sv
// Two-bank ping-pong digest store. The core writes into bank[wr_sel] while
// the host reads bank[rd_sel] either by 1-based address (registered) or as
// a valid/ready word stream. Banks are consumed in load order.
module digest_stream_buffer
  import digest_stream_buffer_pkg::*;
#(
  parameter int WORD_W    = DIGEST_WORD_W,
  parameter int NUM_WORDS = DIGEST_WORDS,
  parameter int ADDR_W    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_i,
  input  logic [NUM_WORDS*WORD_W-1:0] in_words_i,
  input  logic [ADDR_W-1:0]           addr_i,
  output logic [WORD_W-1:0]           out_var_o,
  input  logic                        release_i,
  input  logic                        stream_start_i,
  digest_stream_buffer_if.master      strm,
  output logic [1:0]                  bank_count_o,
  output logic                        overflow_o
);

  // Bank bookkeeping.
  logic [1:0]        full_q, full_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [1:0]        bank_count_q;
  logic              overflow_q;
  logic [WORD_W-1:0] out_var_q, out_var_d;

  // Stream FSM and its registered outputs.
  stream_state_e     state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [WORD_W-1:0] sdata_q;
  logic              svalid_q;
  logic              slast_q;

  // Per-cycle events, all decided from start-of-cycle state.
  logic              rd_full;
  logic              load_acc;
  logic              load_drop;
  logic              hs;
  logic              at_last;
  logic              stream_end;
  logic              start_acc;
  logic              rel_acc;
  logic              free_rd;
  logic [1:0]        bank_we;

  // Bank read ports.
  logic [ADDR_W-1:0] addr_b;
  logic [WORD_W-1:0] rd_a [2];
  logic [WORD_W-1:0] rd_b [2];
  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] str_word;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    digest_stream_buffer_bank #(
      .WORD_W    (WORD_W),
      .NUM_WORDS (NUM_WORDS),
      .ADDR_W    (ADDR_W)
    ) u_bank (
      .clk      (clk),
      .we_i     (bank_we[g]),
      .words_i  (in_words_i),
      .addr_a_i (addr_i),
      .data_a_o (rd_a[g]),
      .addr_b_i (addr_b),
      .data_b_o (rd_b[g])
    );
  end

  // Stream port looks ahead: word 1 when launching, otherwise the next word.
  assign addr_b   = (state_q == ST_IDLE) ? ADDR_W'(1) : (idx_q + ADDR_W'(1));
  assign rd_word  = rd_a[rd_sel_q];
  assign str_word = rd_b[rd_sel_q];

  // Decode load/release/stream events and next-state bank bookkeeping.
  // A stream_start wins over a release in the same IDLE cycle so the bank
  // being launched is never freed underneath the stream.
  always_comb begin
    rd_full    = full_q[rd_sel_q];
    load_acc   = load_i & ~full_q[wr_sel_q];
    load_drop  = load_i &  full_q[wr_sel_q];
    hs         = svalid_q & strm.stream_ready;
    at_last    = (idx_q == ADDR_W'(NUM_WORDS));
    stream_end = (state_q == ST_STREAM) & hs & at_last;
    start_acc  = stream_start_i & (state_q == ST_IDLE) & rd_full;
    rel_acc    = release_i & (state_q == ST_IDLE) & rd_full & ~start_acc;
    free_rd    = rel_acc | stream_end;
    bank_we    = {load_acc & wr_sel_q, load_acc & ~wr_sel_q};
    // Freed and loaded banks are always distinct: one is full, one empty.
    full_d     = (full_q & ~{free_rd & rd_sel_q, free_rd & ~rd_sel_q}) | bank_we;
    wr_sel_d   = wr_sel_q ^ load_acc;
    rd_sel_d   = rd_sel_q ^ free_rd;
    if (rd_full) begin
      out_var_d = rd_word;
    end else begin
      out_var_d = '0;
    end
  end

  // Register bank flags, selects, counters and the random-access read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q       <= 2'b00;
      wr_sel_q     <= 1'b0;
      rd_sel_q     <= 1'b0;
      bank_count_q <= 2'd0;
      overflow_q   <= 1'b0;
      out_var_q    <= '0;
    end else begin
      full_q       <= full_d;
      wr_sel_q     <= wr_sel_d;
      rd_sel_q     <= rd_sel_d;
      bank_count_q <= full_count(full_d);
      overflow_q   <= overflow_q | load_drop;
      out_var_q    <= out_var_d;
    end
  end

  // Stream FSM with registered data/valid/last; outputs hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= ADDR_W'(1);
      sdata_q  <= '0;
      svalid_q <= 1'b0;
      slast_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_acc) begin
            state_q  <= ST_STREAM;
            idx_q    <= ADDR_W'(1);
            sdata_q  <= str_word;
            svalid_q <= 1'b1;
            slast_q  <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (hs) begin
            if (at_last) begin
              state_q  <= ST_IDLE;
              idx_q    <= ADDR_W'(1);
              svalid_q <= 1'b0;
              slast_q  <= 1'b0;
            end else begin
              idx_q   <= idx_q + ADDR_W'(1);
              sdata_q <= str_word;
              slast_q <= ((idx_q + ADDR_W'(1)) == ADDR_W'(NUM_WORDS));
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          idx_q    <= ADDR_W'(1);
          svalid_q <= 1'b0;
          slast_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_var_o         = out_var_q;
  assign bank_count_o      = bank_count_q;
  assign overflow_o        = overflow_q;
  assign strm.stream_data  = sdata_q;
  assign strm.stream_valid = svalid_q;
  assign strm.stream_last  = slast_q;

endmodule
